// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared types for the data-memory arbiter
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// rtl/data_mem_arbiter_rr_pick.sv - round-robin first-set-bit finder starting after ptr
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk ptr+1 .. ptr+N (mod N) and keep the first requester seen
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one data-memory channel; optional DATA_MEM_ARB_PERF_EN counters
module data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef DATA_MEM_ARB_PERF_EN
    output logic [15:0]          perf_grant_count [NUM_CORES],
    output logic [31:0]          perf_busy_cycles,
`endif
    input  logic [NUM_CORES-1:0] core_read_valid,
    input  logic [ADDR_BITS-1:0] core_read_address [NUM_CORES],
    output logic [NUM_CORES-1:0] core_read_ready,
    output logic [DATA_BITS-1:0] core_read_data [NUM_CORES],
    input  logic [NUM_CORES-1:0] core_write_valid,
    input  logic [ADDR_BITS-1:0] core_write_address [NUM_CORES],
    input  logic [DATA_BITS-1:0] core_write_data [NUM_CORES],
    output logic [NUM_CORES-1:0] core_write_ready,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_t           state_q, state_d;
    req_type_t            type_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        gnt_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [NUM_CORES-1:0] pending;
    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic                 grant;

    assign pending = (core_read_valid | core_write_valid) & ~(core_read_ready | core_write_ready);
    assign grant   = (state_q == IDLE) && pick_found;

    rr_pick #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_rr_pick (
        .req   (pending),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register plus the transaction latched at grant time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(NUM_CORES - 1);
            gnt_q    <= '0;
            type_q   <= REQ_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q    <= pick_idx;
                rr_ptr_q <= pick_idx;
                if (core_read_valid[pick_idx]) begin
                    type_q <= REQ_READ;
                    addr_q <= core_read_address[pick_idx];
                end else begin
                    type_q  <= REQ_WRITE;
                    addr_q  <= core_write_address[pick_idx];
                    wdata_q <= core_write_data[pick_idx];
                end
            end
        end
    end

    // Next-state: reads win over writes inside the granted core
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found)
                    state_d = core_read_valid[pick_idx] ? READ_WAIT : WRITE_WAIT;
            end
            READ_WAIT: begin
                if (mem_read_ready)
                    state_d = RELEASE;
            end
            WRITE_WAIT: begin
                if (mem_write_ready)
                    state_d = RELEASE;
            end
            RELEASE: begin
                if (type_q == REQ_READ) begin
                    if (!core_read_valid[gnt_q])
                        state_d = IDLE;
                end else begin
                    if (!core_write_valid[gnt_q])
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-core read data is captured with the memory response and kept after ready drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++)
                core_read_data[i] <= '0;
        end else if (state_q == READ_WAIT && mem_read_ready) begin
            core_read_data[gnt_q] <= mem_read_data;
        end
    end

    // Outputs decoded from state so reset clears them asynchronously
    always_comb begin
        mem_read_valid    = (state_q == READ_WAIT);
        mem_read_address  = addr_q;
        mem_write_valid   = (state_q == WRITE_WAIT);
        mem_write_address = addr_q;
        mem_write_data    = wdata_q;
        core_read_ready   = '0;
        core_write_ready  = '0;
        if (state_q == RELEASE) begin
            if (type_q == REQ_READ)
                core_read_ready[gnt_q] = 1'b1;
            else
                core_write_ready[gnt_q] = 1'b1;
        end
    end

`ifdef DATA_MEM_ARB_PERF_EN
    // Saturating grant counters per core and a wrapping busy-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++)
                perf_grant_count[i] <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (grant && perf_grant_count[pick_idx] != 16'hFFFF)
                perf_grant_count[pick_idx] <= perf_grant_count[pick_idx] + 16'd1;
            if (state_q != IDLE)
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  core_read_valid;
    logic [AW-1:0] core_read_address [N];
    logic [N-1:0]  core_read_ready;
    logic [DW-1:0] core_read_data [N];
    logic [N-1:0]  core_write_valid;
    logic [AW-1:0] core_write_address [N];
    logic [DW-1:0] core_write_data [N];
    logic [N-1:0]  core_write_ready;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic          mem_write_valid;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_ready;
`ifdef DATA_MEM_ARB_PERF_EN
    logic [15:0]   perf_grant_count [N];
    logic [31:0]   perf_busy_cycles;
`endif

    always #5 clk = ~clk;

    data_mem_arbiter #(.NUM_CORES(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk                (clk),
        .reset              (reset),
`ifdef DATA_MEM_ARB_PERF_EN
        .perf_grant_count   (perf_grant_count),
        .perf_busy_cycles   (perf_busy_cycles),
`endif
        .core_read_valid    (core_read_valid),
        .core_read_address  (core_read_address),
        .core_read_ready    (core_read_ready),
        .core_read_data     (core_read_data),
        .core_write_valid   (core_write_valid),
        .core_write_address (core_write_address),
        .core_write_data    (core_write_data),
        .core_write_ready   (core_write_ready),
        .mem_read_valid     (mem_read_valid),
        .mem_read_address   (mem_read_address),
        .mem_read_ready     (mem_read_ready),
        .mem_read_data      (mem_read_data),
        .mem_write_valid    (mem_write_valid),
        .mem_write_address  (mem_write_address),
        .mem_write_data     (mem_write_data),
        .mem_write_ready    (mem_write_ready)
    );

    // Event kinds: 0 mem read, 1 mem write, 2 core read ready, 3 core write ready
    typedef struct {
        int kind;
        int core;
        int addr;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  busy_cnt = 0;
    int  rd_lat   = 3;
    int  wr_lat   = 2;
    logic [DW-1:0] mem [256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int c, input int a, input int d);
        ev_t e;
        e.kind = k; e.core = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int c, input int a, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=kind%0d/core%0d/addr0x%0h required=none", k, c, a);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            if (k == 0 || k == 1) chk("ev_addr", a, e.addr);
            if (k == 1 || k == 2) chk("ev_data", d, e.data);
            if (k == 2 || k == 3) chk("ev_core", c, e.core);
        end
    endtask

    // Memory model: ready pulses for one cycle after a fixed latency
    initial begin
        int rcnt, wcnt;
        rcnt = 0; wcnt = 0;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
        forever begin
            @(negedge clk);
            mem_read_ready  = 1'b0;
            mem_write_ready = 1'b0;
            if (mem_read_valid) begin
                if (rcnt >= rd_lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem[mem_read_address];
                    rcnt = 0;
                end else rcnt++;
            end else rcnt = 0;
            if (mem_write_valid) begin
                if (wcnt >= wr_lat) begin
                    mem_write_ready = 1'b1;
                    mem[mem_write_address] = mem_write_data;
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // Monitor: pops the scoreboard on each rising valid/ready and checks invariants
    initial begin
        logic p_mrv, p_mwv;
        logic [N-1:0] p_crr, p_cwr;
        p_mrv = 0; p_mwv = 0; p_crr = '0; p_cwr = '0;
        forever begin
            @(negedge clk);
            if (mem_read_valid && mem_write_valid)
                chk("mem_valid_overlap", 1, 0);
            if ($countones({core_read_ready, core_write_ready}) > 1)
                chk("ready_onehot", $countones({core_read_ready, core_write_ready}), 1);
            if (mem_read_valid || mem_write_valid || (|core_read_ready) || (|core_write_ready))
                busy_cnt++;
            if (mem_read_valid && !p_mrv) observe(0, 0, mem_read_address, 0);
            if (mem_write_valid && !p_mwv) observe(1, 0, mem_write_address, mem_write_data);
            for (int g = 0; g < N; g++) begin
                if (core_read_ready[g] && !p_crr[g]) observe(2, g, 0, core_read_data[g]);
                if (core_write_ready[g] && !p_cwr[g]) observe(3, g, 0, 0);
            end
            p_mrv = mem_read_valid; p_mwv = mem_write_valid;
            p_crr = core_read_ready; p_cwr = core_write_ready;
        end
    end

    task automatic core_read(input int c, input logic [AW-1:0] a);
        int n;
        core_read_address[c] = a;
        core_read_valid[c]   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!core_read_ready[c] && n < 200);
        if (!core_read_ready[c]) begin
            checks++; failures++;
            $display("FAIL read_timeout core%0d actual=no_ready required=ready", c);
        end
        core_read_valid[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic core_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        core_write_address[c] = a;
        core_write_data[c]    = d;
        core_write_valid[c]   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!core_write_ready[c] && n < 200);
        if (!core_write_ready[c]) begin
            checks++; failures++;
            $display("FAIL write_timeout core%0d actual=no_ready required=ready", c);
        end
        core_write_valid[c] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        core_read_valid = '0;
        core_write_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        busy_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        core_read_valid = '0;
        core_write_valid = '0;
        for (int i = 0; i < N; i++) begin
            core_read_address[i] = '0; core_write_address[i] = '0; core_write_data[i] = '0;
        end
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 8'hA5; mem[8'h20] = 8'h3C; mem[8'h61] = 8'h5A; mem[8'h62] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            mem[8'h40 + i] = 8'(8'h80 + i);
            mem[8'h50 + i] = 8'(8'h90 + i);
        end
        repeat (2) @(negedge clk);
        chk("rst_mem_read_valid", mem_read_valid, 0);
        chk("rst_mem_write_valid", mem_write_valid, 0);
        chk("rst_read_ready", core_read_ready, 0);
        chk("rst_write_ready", core_write_ready, 0);
        chk("rst_read_data0", core_read_data[0], 0);
        chk("rst_mem_addr", mem_read_address, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single read from core0
        expect_ev(0, 0, 8'h10, 0);
        expect_ev(2, 0, 0, 8'hA5);
        core_read(0, 8'h10);
        chk("read_ready_dropped", core_read_ready, 0);
        chk("read_data_kept", core_read_data[0], 8'hA5);

        // Contention out of reset: core0 then core1
        do_reset();
        expect_ev(1, 0, 8'h30, 8'h11);
        expect_ev(3, 0, 0, 0);
        expect_ev(1, 0, 8'h31, 8'h22);
        expect_ev(3, 1, 0, 0);
        fork
            core_write(0, 8'h30, 8'h11);
            core_write(1, 8'h31, 8'h22);
        join
        chk("mem_0x30", mem[8'h30], 8'h11);
        chk("mem_0x31", mem[8'h31], 8'h22);
`ifdef DATA_MEM_ARB_PERF_EN
        chk("perf_grant0", perf_grant_count[0], 1);
        chk("perf_grant1", perf_grant_count[1], 1);
        chk("perf_busy", perf_busy_cycles, busy_cnt);
`endif

        // Read and write together from core1: read first
        expect_ev(0, 0, 8'h20, 0);
        expect_ev(2, 1, 0, 8'h3C);
        expect_ev(1, 0, 8'h21, 8'h7E);
        expect_ev(3, 1, 0, 0);
        fork
            core_read(1, 8'h20);
            core_write(1, 8'h21, 8'h7E);
        join
        chk("mem_0x21", mem[8'h21], 8'h7E);

        // Round-robin: both cores continuously, alternating from core0
        for (int i = 0; i < 4; i++) begin
            expect_ev(0, 0, 8'h40 + i, 0);
            expect_ev(2, 0, 0, 8'h80 + i);
            expect_ev(0, 0, 8'h50 + i, 0);
            expect_ev(2, 1, 0, 8'h90 + i);
        end
        fork
            for (int i = 0; i < 4; i++) core_read(0, 8'(8'h40 + i));
            for (int j = 0; j < 4; j++) core_read(1, 8'(8'h50 + j));
        join

        // Reset during READ_WAIT
        rd_lat = 20;
        expect_ev(0, 0, 8'h60, 0);
        core_read_address[1] = 8'h60;
        core_read_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("midop_read_valid", mem_read_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_read_valid", mem_read_valid, 0);
        chk("abort_read_addr", mem_read_address, 0);
        chk("abort_ready", {core_read_ready, core_write_ready}, 0);
        chk("abort_read_data1", core_read_data[1], 0);
        core_read_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd_lat = 3;
        expect_ev(0, 0, 8'h61, 0);
        expect_ev(2, 0, 0, 8'h5A);
        expect_ev(0, 0, 8'h62, 0);
        expect_ev(2, 1, 0, 8'hC3);
        fork
            core_read(0, 8'h61);
            core_read(1, 8'h62);
        join

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
